// File: rtl/aes_pkg.sv
// Shared AES types, direction constants, round FSM encoding and GF(2^8) helpers.
package aes_pkg;

    typedef logic [127:0] state_t;

    localparam bit OP_ENC = 1'b1;
    localparam bit OP_DEC = 1'b0;

    // Start-to-done latency of sub_bytes; fixed by its two pipeline stages.
    localparam int SB_LAT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        SB_WAIT = 2'd2
    } round_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
    endfunction

endpackage

// File: rtl/mix_columns.sv
// Combinational MixColumns (forward or inverse) on a column-major state.
module mix_columns
    import aes_pkg::*;
#(
    parameter bit OP = OP_ENC
) (
    input  state_t i_state,
    output state_t o_state
);

    localparam logic [7:0] C0 = (OP == OP_ENC) ? 8'h02 : 8'h0e;
    localparam logic [7:0] C1 = (OP == OP_ENC) ? 8'h03 : 8'h0b;
    localparam logic [7:0] C2 = (OP == OP_ENC) ? 8'h01 : 8'h0d;
    localparam logic [7:0] C3 = (OP == OP_ENC) ? 8'h01 : 8'h09;

    genvar gi;
    genvar gr;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] w_a [4];
            for (gr = 0; gr < 4; gr++) begin : g_in
                assign w_a[gr] = i_state[127-8*(4*gi+gr) -: 8];
            end
            // Circulant matrix: row r starts its coefficient rotation at byte r.
            for (gr = 0; gr < 4; gr++) begin : g_out
                assign o_state[127-8*(4*gi+gr) -: 8] =
                    gmul(w_a[gr], C0) ^ gmul(w_a[(gr+1)%4], C1) ^
                    gmul(w_a[(gr+2)%4], C2) ^ gmul(w_a[(gr+3)%4], C3);
            end
        end
    endgenerate

endmodule

// File: rtl/shift_rows.sv
// Combinational ShiftRows on a column-major state (byte 0 in the top bits).
module shift_rows
    import aes_pkg::*;
#(
    parameter bit OP = OP_ENC
) (
    input  state_t i_state,
    output state_t o_state
);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW     = gi % 4;
            localparam int COL     = gi / 4;
            localparam int SRC_COL = (OP == OP_ENC) ? (COL + ROW) % 4 : (COL + 4 - ROW) % 4;
            localparam int SRC     = SRC_COL * 4 + ROW;
            assign o_state[127-8*gi -: 8] = i_state[127-8*SRC -: 8];
        end
    endgenerate

endmodule

// File: rtl/sub_bytes.sv
// Two-stage pipelined SubBytes over WIDTH/8 bytes; done follows start by SB_LAT cycles.
module sub_bytes
    import aes_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter bit OP    = OP_ENC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_done
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] w_mid;
    logic [WIDTH-1:0] w_fin;
    logic [WIDTH-1:0] r_mid;
    logic [WIDTH-1:0] r_out;
    logic             r_vld;
    logic             r_done;

    // Forward: inverse then affine. Inverse: inverse-affine then inverse.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            if (OP == OP_ENC) begin : g_enc
                assign w_mid[gi*8 +: 8] = ginv(i_data[gi*8 +: 8]);
                assign w_fin[gi*8 +: 8] = affine(r_mid[gi*8 +: 8]);
            end else begin : g_dec
                assign w_mid[gi*8 +: 8] = inv_affine(i_data[gi*8 +: 8]);
                assign w_fin[gi*8 +: 8] = ginv(r_mid[gi*8 +: 8]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mid  <= '0;
            r_out  <= '0;
            r_vld  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_vld  <= i_start;
            r_done <= r_vld;
            if (i_start) r_mid <= w_mid;
            if (r_vld)   r_out <= w_fin;
        end
    end

    assign o_data = r_out;
    assign o_done = r_done;

endmodule

// File: rtl/round_tf.sv
// One forward AES round without AddRoundKey. Define ROUND_TF_OUT_REG_EN to add
// an output pipeline register (one extra cycle of latency, same result).
module round_tf
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         bypass_mc_i,
    input  logic [127:0] s_i,
    output logic [127:0] s_o,
    output logic         done_o,
    output logic         busy_o
);

    round_state_t r_state;
    round_state_t w_state_next;

    state_t r_cap;
    logic   r_bypass;
    state_t r_s_o;
    logic   r_done;

    logic   w_busy;
    logic   w_accept;
    logic   w_sb_start;
    logic   w_sb_done;
    logic   w_fin_load;
    state_t w_sb_out;
    state_t w_sr;
    state_t w_mc;
    state_t w_res;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_next = LAUNCH;
            LAUNCH:                 w_state_next = SB_WAIT;
            SB_WAIT: if (w_sb_done) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

`ifdef ROUND_TF_OUT_REG_EN
    state_t r_pipe;
    logic   r_pipe_vld;
`endif

    always_comb begin
        w_busy     = (r_state != IDLE);
`ifdef ROUND_TF_OUT_REG_EN
        w_busy     = w_busy | r_pipe_vld;
`endif
        w_sb_start = (r_state == LAUNCH) && !rst;
        w_fin_load = (r_state == SB_WAIT) && w_sb_done;
        w_accept   = start_i && !w_busy && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap    <= '0;
            r_bypass <= 1'b0;
        end else if (w_accept) begin
            r_cap    <= s_i;
            r_bypass <= bypass_mc_i;
        end
    end

    sub_bytes #(
        .WIDTH (128),
        .OP    (OP_ENC)
    ) u_sub_bytes (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_sb_start),
        .i_data  (r_cap),
        .o_data  (w_sb_out),
        .o_done  (w_sb_done)
    );

    shift_rows #(
        .OP (OP_ENC)
    ) u_shift_rows (
        .i_state (w_sb_out),
        .o_state (w_sr)
    );

    mix_columns #(
        .OP (OP_ENC)
    ) u_mix_columns (
        .i_state (w_sr),
        .o_state (w_mc)
    );

    assign w_res = r_bypass ? w_sr : w_mc;

`ifdef ROUND_TF_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe     <= '0;
            r_pipe_vld <= 1'b0;
            r_s_o      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_pipe_vld <= w_fin_load;
            r_done     <= r_pipe_vld;
            if (w_fin_load) r_pipe <= w_res;
            if (r_pipe_vld) r_s_o  <= r_pipe;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_o  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fin_load;
            if (w_fin_load) r_s_o <= w_res;
        end
    end
`endif

    assign s_o    = r_s_o;
    assign done_o = r_done && !rst;
    assign busy_o = w_busy && !rst;

endmodule

// File: tb/tb_round_tf.sv
// Scoreboard bench for round_tf: stimulus queues expected results, a monitor checks each done_o.
module tb_round_tf;

    localparam int SB_LAT = 2;
`ifdef ROUND_TF_OUT_REG_EN
    localparam int LAT = SB_LAT + 3;
`else
    localparam int LAT = SB_LAT + 2;
`endif

    localparam logic [127:0] VEC_A    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_A_MC = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] VEC_A_SR = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] VEC_B    = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] VEC_B_MC = 128'h584dcaf11b4b5aacdbe7caa81b6bb0e5;
    localparam logic [127:0] ALL_63   = 128'h63636363636363636363636363636363;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         bypass_mc_i;
    logic [127:0] s_i;
    logic [127:0] s_o;
    logic         done_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [127:0] q_val [$];
    int           q_due [$];

    round_tf dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .bypass_mc_i (bypass_mc_i),
        .s_i         (s_i),
        .s_o         (s_o),
        .done_o      (done_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    // Monitor: every done_o pops one expected result and its due cycle.
    always @(negedge clk) begin
        logic [127:0] exp_v;
        int           exp_d;
        if (done_o) begin
            if (q_val.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done cycle %0d s_o %h required no done_o", cyc, s_o);
            end else begin
                exp_v = q_val.pop_front();
                exp_d = q_due.pop_front();
                $display("done cycle %0d s_o %h expected %h due %0d", cyc, s_o, exp_v, exp_d);
                chk("result_s_o", s_o, exp_v);
                chk("done_cycle", 128'(cyc), 128'(exp_d));
            end
        end
    end

    // Drive one start pulse from a negedge; returns on the following negedge.
    task automatic issue(input logic [127:0] v, input logic byp,
                         input logic [127:0] exp_v, input bit accepted);
        s_i         = v;
        bypass_mc_i = byp;
        start_i     = 1'b1;
        if (accepted) begin
            q_val.push_back(exp_v);
            q_due.push_back(cyc + LAT);
        end
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n = 0;
        while (!done_o && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual no done_o required done_o within %0d cycles", tag, bound);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        bypass_mc_i = 1'b0;
        s_i         = '0;
        repeat (3) @(negedge clk);

        // start during reset must be ignored
        s_i     = VEC_A;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("reset_s_o", s_o, '0);
        chk("reset_done", 128'(done_o), 128'(0));
        chk("reset_busy", 128'(busy_o), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", 128'(busy_o), 128'(0));

        // Round with MixColumns; a second start two cycles later is ignored
        issue(VEC_A, 1'b0, VEC_A_MC, 1'b1);
        chk("busy_launch", 128'(busy_o), 128'(1));
        @(negedge clk);
        issue(128'h0, 1'b1, 128'h0, 1'b0);
        s_i = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
        wait_done(4 * LAT, "round_a");
        chk("busy_in_done", 128'(busy_o), 128'(0));

        // Back-to-back start in the done cycle, final-round form
        issue(128'h0, 1'b1, ALL_63, 1'b1);
        chk("done_single_pulse", 128'(done_o), 128'(0));
        chk("s_o_hold", s_o, VEC_A_MC);
        chk("busy_b2b", 128'(busy_o), 128'(1));
        wait_done(4 * LAT, "round_zero");
        @(negedge clk);

        issue(VEC_A, 1'b1, VEC_A_SR, 1'b1);
        wait_done(4 * LAT, "round_a_bypass");
        @(negedge clk);

        issue(VEC_B, 1'b0, VEC_B_MC, 1'b1);
        wait_done(4 * LAT, "round_b");
        @(negedge clk);

        // Reset one cycle into SB_WAIT aborts the round
        issue(VEC_B, 1'b0, 128'h0, 1'b0);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        chk("abort_busy_in_rst", 128'(busy_o), 128'(0));
        rst     = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 2 * SB_LAT + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", 128'(done_o), 128'(0));
        end
        chk("abort_s_o", s_o, '0);
        chk("abort_busy", 128'(busy_o), 128'(0));

        chk("scoreboard_empty", 128'(q_val.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual simulation still running required finish");
        $fatal(1);
    end

endmodule

// File: doc/round_tf.md
ROUND_TF -- requirements
Module: round_tf

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start_i  input  1  single-cycle request to run one forward round on s_i.
REQ-004 bypass_mc_i  input  1  when 1, skip MixColumns (final round); sampled with start_i.
REQ-005 s_i  input  128  input state; column-major, s_i[127:120] = byte 0 (row 0, col 0).
REQ-006 s_o  output  128  result state, same byte order, registered.
REQ-007 done_o  output  1  one-cycle pulse marking s_o valid.
REQ-008 busy_o  output  1  high while a round is in flight.

Function
REQ-009 Transform SHALL be s_o = MixColumns(ShiftRows(SubBytes(s_i))), or ShiftRows(SubBytes(s_i)) when bypass_mc_i=1; no AddRoundKey.
REQ-010 FSM states SHALL be IDLE, LAUNCH, SB_WAIT; IDLE->LAUNCH on start_i, LAUNCH->SB_WAIT unconditionally, SB_WAIT->IDLE on sub_bytes done.
REQ-011 In IDLE with start_i=1, s_i and bypass_mc_i SHALL be captured into internal registers; later input changes are ignored.
REQ-012 In LAUNCH, a one-cycle start pulse SHALL be issued to sub_bytes with the captured state.
REQ-013 On the sub_bytes done cycle, ShiftRows/MixColumns SHALL be applied combinationally and the result registered into s_o.
REQ-014 Latency: start_i sampled at edge 0 SHALL yield done_o=1 in cycle SB_LAT+2, where SB_LAT is the sub_bytes start-to-done latency.
REQ-015 busy_o SHALL be 1 in LAUNCH and SB_WAIT and 0 in IDLE, including the done_o cycle.
REQ-016 start_i while busy_o=1 SHALL be ignored: no capture, no queueing, no effect on the current round.
REQ-017 start_i in the done_o cycle SHALL be accepted, so back-to-back rounds are supported.
REQ-018 s_o SHALL hold its value from done_o until the next result is registered.
REQ-019 done_o SHALL never be asserted on two consecutive cycles for a single start.

Reset
REQ-020 While rst=1: state=IDLE, s_o=0, done_o=0, busy_o=0, captured registers=0, sub_bytes start=0.
REQ-021 Reset mid-round SHALL abort the round; no done_o follows, and any sub_bytes done arriving afterwards is ignored in IDLE.
REQ-022 start_i is ignored in any cycle where rst=1.

Configuration
REQ-023 With macro ROUND_TF_OUT_REG_EN defined, an extra pipeline register SHALL follow the ShiftRows/MixColumns stage; done_o and s_o then move to cycle SB_LAT+3, and busy_o stays 1 through the extra cycle.
REQ-024 With ROUND_TF_OUT_REG_EN undefined, the latency SHALL be exactly as in REQ-014.
REQ-025 The function result SHALL be identical either way.

Structure
REQ-026 The shared package aes_pkg SHALL hold state_t (128-bit), the OP_ENC=1 and OP_DEC=0 direction constants, and the round FSM state enum.
REQ-027 Sub-module sub_bytes SHALL be instantiated with WIDTH=128 and OP=OP_ENC.
REQ-028 The existing shift_rows and mix_columns blocks SHALL be instantiated combinationally with OP=OP_ENC.
REQ-029 No other new sub-modules.

Verification
REQ-030 s_i=193de3bea0f4e22b9ac68d2ae9f84808, bypass=0, start pulse -> done_o at SB_LAT+2, s_o=046681e5e0cb199a48f8d37a2806264c.
REQ-031 Same s_i, bypass=1 -> s_o=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-032 Second start_i with s_i=0 two cycles after the first -> ignored; the single done_o carries the REQ-030 value.
REQ-033 start_i in the done_o cycle with s_i=0, bypass=1 -> second done_o after SB_LAT+2 cycles, s_o=63636363636363636363636363636363.
REQ-034 rst asserted one cycle into SB_WAIT -> no done_o for 2*SB_LAT cycles, s_o=0, busy_o=0.
REQ-035 ROUND_TF_OUT_REG_EN defined, REQ-030 stimulus -> same s_o, done_o at SB_LAT+3.
